retire_monitor: RTL and testbench

RETIRE_MONITOR -- requirements
Module: retire_monitor

---
 rtl/retire_monitor_pkg.sv | 20 ++
 rtl/retire_monitor_if.sv | 25 ++
 rtl/retire_monitor.sv | 100 ++++++++++
 tb/tb_retire_monitor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/retire_monitor_pkg.sv
// Shared definitions for the retirement monitor: halt-pair encodings and
// the halt FSM state type.
package retire_monitor_pkg;

    // Default halt pair: "li ra,12" followed by "ret".
    localparam logic [31:0] HALT_INST0_ENC = 32'h00c00093;
    localparam logic [31:0] HALT_INST1_ENC = 32'h00008067;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StHalted
    } halt_state_e;

    // Saturating 32-bit increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFFFFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/retire_monitor_if.sv
// Retirement stream from the core: one instruction per cycle at most.
interface retire_monitor_if;

    logic        RET_VALID;
    logic [31:0] RET_INST;
    logic        RET_OUT_EN;
    logic [31:0] RET_OUT_VAL;

    // Core side drives retirements.
    modport master (
        output RET_VALID,
        output RET_INST,
        output RET_OUT_EN,
        output RET_OUT_VAL
    );

    // Monitor side observes them.
    modport slave (
        input RET_VALID,
        input RET_INST,
        input RET_OUT_EN,
        input RET_OUT_VAL
    );

endinterface

// File: rtl/retire_monitor.sv
// Retirement monitor: counts retired instructions and cycles, captures the
// last observable result, detects the halt instruction pair and runs a
// no-retirement watchdog. Once halted or timed out, everything freezes.
module retire_monitor
    import retire_monitor_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1024,
    parameter logic [31:0] HALT_INST0 = HALT_INST0_ENC,
    parameter logic [31:0] HALT_INST1 = HALT_INST1_ENC
) (
    input  logic                    CLK,
    input  logic                    RST,
    retire_monitor_if.slave         ret,
    output logic [31:0]             NUM_INST,
    output logic [31:0]             OUTPUT_PORT,
    output logic                    HALT,
    output logic                    TIMEOUT,
    output logic [31:0]             CYCLE
);

    halt_state_e state_q, state_d;
    logic [31:0] num_inst_q, num_inst_d;
    logic [31:0] output_q, output_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;
    logic        frozen;

    assign frozen = (state_q == StHalted) || timeout_q;

    // Counters, result capture and watchdog next state.
    always_comb begin
        num_inst_d = num_inst_q;
        output_d   = output_q;
        cycle_d    = cycle_q;
        idle_d     = idle_q;
        timeout_d  = timeout_q;
        if (!frozen) begin
            cycle_d = sat_inc(cycle_q);
            if (ret.RET_VALID) begin
                num_inst_d = sat_inc(num_inst_q);
                if (ret.RET_OUT_EN) begin
                    output_d = ret.RET_OUT_VAL;
                end
                // A retirement always beats a watchdog expiry in the same cycle.
                idle_d = '0;
            end else begin
                idle_d = idle_q + 32'd1;
                if (idle_d == WDOG_LIMIT) begin
                    timeout_d = 1'b1;
                end
            end
        end
    end

    // Halt-pair FSM next state; bubbles leave ARMED untouched.
    always_comb begin
        state_d = state_q;
        if (!frozen && ret.RET_VALID) begin
            unique case (state_q)
                StIdle: begin
                    if (ret.RET_INST == HALT_INST0) state_d = StArmed;
                end
                StArmed: begin
                    if (ret.RET_INST == HALT_INST1)      state_d = StHalted;
                    else if (ret.RET_INST == HALT_INST0) state_d = StArmed;
                    else                                 state_d = StIdle;
                end
                StHalted: state_d = StHalted;
                default:  state_d = StIdle;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            num_inst_q <= '0;
            output_q   <= '0;
            cycle_q    <= '0;
            idle_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
            output_q   <= output_d;
            cycle_q    <= cycle_d;
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
        end
    end

    assign NUM_INST    = num_inst_q;
    assign OUTPUT_PORT = output_q;
    assign HALT        = (state_q == StHalted);
    assign TIMEOUT     = timeout_q;
    assign CYCLE       = cycle_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Randomized and directed bench for retire_monitor against a behavioural
// model that tracks "last retirement was the first halt word".
module tb_retire_monitor;

    localparam int unsigned WDOG = 8;
    localparam logic [31:0] I0   = 32'h00c00093;
    localparam logic [31:0] I1   = 32'h00008067;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        CLK;
    logic        RST;
    logic [31:0] NUM_INST, OUTPUT_PORT, CYCLE;
    logic        HALT, TIMEOUT;

    retire_monitor_if rif ();

    retire_monitor #(
        .WDOG_LIMIT (WDOG)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ret         (rif.slave),
        .NUM_INST    (NUM_INST),
        .OUTPUT_PORT (OUTPUT_PORT),
        .HALT        (HALT),
        .TIMEOUT     (TIMEOUT),
        .CYCLE       (CYCLE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    logic [31:0] m_num, m_out, m_cycle;
    int unsigned m_idle;
    bit          m_halt, m_timeout, m_armed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".num"},   NUM_INST,           m_num);
        check({tag, ".out"},   OUTPUT_PORT,        m_out);
        check({tag, ".cycle"}, CYCLE,              m_cycle);
        check({tag, ".halt"},  {31'd0, HALT},      {31'd0, m_halt});
        check({tag, ".tmo"},   {31'd0, TIMEOUT},   {31'd0, m_timeout});
    endtask

    function automatic void model_reset();
        m_num = 0; m_out = 0; m_cycle = 0; m_idle = 0;
        m_halt = 0; m_timeout = 0; m_armed = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [31:0] inst,
                                       input bit en, input logic [31:0] val);
        if (m_halt || m_timeout) return;
        if (m_cycle != 32'hFFFFFFFF) m_cycle++;
        if (v) begin
            if (m_num != 32'hFFFFFFFF) m_num++;
            if (en) m_out = val;
            m_idle = 0;
            if (m_armed && inst == I1) m_halt = 1;
            else m_armed = (inst == I0);
        end else begin
            m_idle++;
            if (m_idle == WDOG) m_timeout = 1;
        end
    endfunction

    // One clock: drive, step model at the edge, compare 1 time unit later.
    task automatic cyc(input bit v, input logic [31:0] inst, input bit en,
                       input logic [31:0] val, input string tag);
        rif.RET_VALID   = v;
        rif.RET_INST    = inst;
        rif.RET_OUT_EN  = en;
        rif.RET_OUT_VAL = val;
        @(posedge CLK);
        model_step(v, inst, en, val);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        rif.RET_VALID   = 1'b0;
        rif.RET_INST    = '0;
        rif.RET_OUT_EN  = 1'b0;
        rif.RET_OUT_VAL = '0;
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int thresh;
        int sel;
        logic [31:0] inst;
        RST = 1'b0;
        rif.RET_VALID = 1'b0; rif.RET_INST = '0; rif.RET_OUT_EN = 1'b0; rif.RET_OUT_VAL = '0;
        model_reset();
        @(posedge CLK); #1;
        do_reset("rst0");

        // Five results 5,0,1,0,1.
        cyc(1, NOP, 1, 5, "r5a"); cyc(1, NOP, 1, 0, "r5b"); cyc(1, NOP, 1, 1, "r5c");
        cyc(1, NOP, 1, 0, "r5d"); cyc(1, NOP, 1, 1, "r5e");
        check("five.num", NUM_INST, 32'd5);
        check("five.out", OUTPUT_PORT, 32'd1);
        check("five.halt", {31'd0, HALT}, 32'd0);

        // Invalid cycle ignores result fields.
        cyc(0, I0, 1, 32'hDEADBEEF, "bub");
        check("bub.out", OUTPUT_PORT, 32'd1);
        check("bub.num", NUM_INST, 32'd5);

        // Halt pair with bubbles in between.
        do_reset("rst1");
        cyc(1, I0, 0, 0, "hp0"); cyc(0, 0, 0, 0, "hpb"); cyc(0, 0, 0, 0, "hpb");
        cyc(0, 0, 0, 0, "hpb");
        check("hp.prehalt", {31'd0, HALT}, 32'd0);
        cyc(1, I1, 1, 32'h77, "hp1");
        check("hp.halt", {31'd0, HALT}, 32'd1);
        check("hp.num", NUM_INST, 32'd2);
        cyc(1, NOP, 1, 32'h99, "hpf"); cyc(1, NOP, 1, 32'h98, "hpf");
        check("hp.frozen", NUM_INST, 32'd2);

        // Async reset while halted.
        #2; RST = 1'b1; model_reset(); #1;
        check("arst.num", NUM_INST, 32'd0);
        check("arst.halt", {31'd0, HALT}, 32'd0);
        check("arst.cycle", CYCLE, 32'd0);
        check("arst.out", OUTPUT_PORT, 32'd0);
        #1; RST = 1'b0;
        cyc(1, I1, 0, 0, "arst.i1");
        check("arst.idle", {31'd0, HALT}, 32'd0);

        // Broken pair.
        do_reset("rst2");
        cyc(1, I0, 0, 0, "bp0"); cyc(1, NOP, 0, 0, "bp1"); cyc(1, I1, 0, 0, "bp2");
        check("bp.halt", {31'd0, HALT}, 32'd0);
        check("bp.num", NUM_INST, 32'd3);

        // Watchdog expiry.
        do_reset("rst3");
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, "wd");
        check("wd.pre", {31'd0, TIMEOUT}, 32'd0);
        cyc(0, 0, 0, 0, "wd8");
        check("wd.tmo", {31'd0, TIMEOUT}, 32'd1);
        check("wd.cycle", CYCLE, 32'd8);
        cyc(1, NOP, 1, 3, "wdf"); cyc(0, 0, 0, 0, "wdf");
        check("wd.frozen", CYCLE, 32'd8);

        // Retirement on the expiry cycle wins.
        do_reset("rst4");
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, "wr");
        cyc(1, NOP, 0, 0, "wr8");
        check("wr.tmo", {31'd0, TIMEOUT}, 32'd0);
        check("wr.num", NUM_INST, 32'd1);

        // Halt word lands on the expiry cycle.
        do_reset("rst5");
        cyc(1, I0, 0, 0, "wh0");
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, "wh");
        cyc(1, I1, 0, 0, "wh1");
        check("wh.halt", {31'd0, HALT}, 32'd1);
        check("wh.tmo", {31'd0, TIMEOUT}, 32'd0);

        // Random segments.
        for (int seg = 0; seg < 30; seg++) begin
            do_reset("rrst");
            thresh = $urandom_range(1, 9);
            for (int i = 0; i < 60; i++) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: inst = I0;
                    1: inst = I1;
                    2: inst = NOP;
                    default: inst = $urandom;
                endcase
                cyc($urandom_range(0, 9) < thresh, inst, $urandom_range(0, 1) == 1,
                    $urandom, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
